mole_target: RTL and testbench

Target-side node for the whack-a-mole game: the counterpart of the game controller, which drives a "target up" level and listens for a falling edge on a hit line. This block receives the target-up command, drives the target lamp, and synchronizes and debounces the raw hit sensor. While the target is up, it returns a clean active-low hit pulse to the controller, together with a reaction time and a miss indication. One instance sits between each physical target and the game controller.

---
 rtl/mole_pkg.sv | 16 +
 rtl/input_debounce.sv | 42 ++++
 rtl/mole_target.sv | 111 +++++++++++
 tb/tb_mole_target.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and default timing constants for the whack-a-mole target node
// and the game controller.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        HIT       = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
    localparam int TICK_DIV        = CLK_HZ / 1000;  // 1 ms

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer: dout follows
// the synchronized input only after it has differed for DEBOUNCE_CYCLES cycles.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = mole_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            // any cycle that agrees with dout restarts the stability run
            if (sync1 != dout) begin
                if (cnt == LAST) begin
                    dout <= sync1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mole_target.sv
// Target-side node: lamp drive, debounced hit detection, active-low hit pulse,
// reaction-time measurement and miss reporting back to the game controller.
module mole_target #(
    parameter int DEBOUNCE_CYCLES  = mole_pkg::DEBOUNCE_CYCLES,
    parameter int HIT_PULSE_CYCLES = 4,
    parameter int TICK_DIV         = mole_pkg::TICK_DIV,
    parameter int RT_W             = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            target_up,
    input  logic            sensor_raw,
    output logic            lamp,
    output logic            hit_n,
    output logic            hit_valid,
    output logic [RT_W-1:0] reaction_ms,
    output logic            miss,
    output logic            sensor_clean
);
    import mole_pkg::*;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (HIT_PULSE_CYCLES > 1) ? $clog2(HIT_PULSE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(HIT_PULSE_CYCLES - 1);

    state_t          state;
    logic            clean_d;
    logic            press;
    logic [TW-1:0]   tick;
    logic [RT_W-1:0] rt_cnt;
    logic [PW-1:0]   pulse_cnt;

    input_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .resetn(resetn),
        .din   (sensor_raw),
        .dout  (sensor_clean)
    );

    // only a fresh rising edge counts; a level already held at arming does not
    assign press = sensor_clean & ~clean_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            lamp        <= 1'b0;
            hit_n       <= 1'b1;
            hit_valid   <= 1'b0;
            miss        <= 1'b0;
            reaction_ms <= '0;
            clean_d     <= 1'b0;
            tick        <= '0;
            rt_cnt      <= '0;
            pulse_cnt   <= '0;
        end else begin
            clean_d   <= sensor_clean;
            hit_valid <= 1'b0;
            miss      <= 1'b0;
            case (state)
                IDLE: begin
                    if (target_up) begin
                        state  <= ARMED;
                        lamp   <= 1'b1;
                        tick   <= '0;
                        rt_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (rt_cnt != '1)
                            rt_cnt <= rt_cnt + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    // a press in the same cycle as target_up falling is a hit
                    if (press) begin
                        state       <= HIT;
                        lamp        <= 1'b0;
                        hit_n       <= 1'b0;
                        hit_valid   <= 1'b1;
                        reaction_ms <= rt_cnt;
                        pulse_cnt   <= '0;
                    end else if (!target_up) begin
                        state <= IDLE;
                        lamp  <= 1'b0;
                        miss  <= 1'b1;
                    end
                end
                HIT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= WAIT_DROP;
                        hit_n     <= 1'b1;
                        pulse_cnt <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                WAIT_DROP: begin
                    if (!target_up)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_target.sv
// Directed scenarios plus a random phase, every cycle compared against a
// behavioural model of the target node kept in this bench.
module tb_mole_target;
    import mole_pkg::*;

    localparam int DEB  = 4;
    localparam int PUL  = 3;
    localparam int TDIV = 10;
    localparam int RTW  = 4;
    localparam int RMAX = (1 << RTW) - 1;

    localparam int P_IDLE = 0, P_ARMED = 1, P_HIT = 2, P_WAIT = 3;

    logic           clk;
    logic           resetn;
    logic           target_up;
    logic           sensor_raw;
    logic           lamp;
    logic           hit_n;
    logic           hit_valid;
    logic [RTW-1:0] reaction_ms;
    logic           miss;
    logic           sensor_clean;

    mole_target #(
        .DEBOUNCE_CYCLES (DEB),
        .HIT_PULSE_CYCLES(PUL),
        .TICK_DIV        (TDIV),
        .RT_W            (RTW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .target_up   (target_up),
        .sensor_raw  (sensor_raw),
        .lamp        (lamp),
        .hit_n       (hit_n),
        .hit_valid   (hit_valid),
        .reaction_ms (reaction_ms),
        .miss        (miss),
        .sensor_clean(sensor_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_hist[$];     // raw samples still travelling through the synchronizer
    bit m_win[$];      // last DEB synchronized samples
    bit m_clean, m_rose;
    int m_phase, m_el, m_left, m_rt;
    bit m_lamp, m_hitn, m_hv, m_miss;

    task automatic model_reset();
        m_hist.delete(); m_hist.push_back(1'b0); m_hist.push_back(1'b0);
        m_win.delete();
        m_clean = 0; m_rose = 0;
        m_phase = P_IDLE; m_el = 0; m_left = 0; m_rt = 0;
        m_lamp = 0; m_hitn = 1; m_hv = 0; m_miss = 0;
    endtask

    task automatic model_step();
        bit seen, flip, press;
        int rpt;
        if (!resetn) begin
            model_reset();
            return;
        end
        seen = m_hist.pop_front();
        m_hist.push_back(sensor_raw);
        press = m_rose;
        m_win.push_back(seen);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        flip = (m_win.size() == DEB);
        foreach (m_win[i]) if (m_win[i] == m_clean) flip = 0;
        if (flip) m_clean = !m_clean;
        m_rose = flip && m_clean;
        m_hv = 0; m_miss = 0;
        case (m_phase)
            P_IDLE: if (target_up) begin
                m_phase = P_ARMED; m_lamp = 1; m_el = 0;
            end
            P_ARMED: begin
                rpt = m_el / TDIV;
                if (rpt > RMAX) rpt = RMAX;
                if (press) begin
                    m_phase = P_HIT; m_lamp = 0; m_hitn = 0; m_hv = 1;
                    m_rt = rpt; m_left = PUL;
                end else if (!target_up) begin
                    m_phase = P_IDLE; m_lamp = 0; m_miss = 1;
                end
                m_el++;
            end
            P_HIT: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_WAIT; m_hitn = 1; end
            end
            default: if (!target_up) m_phase = P_IDLE;
        endcase
    endtask

    initial model_reset();
    always @(posedge clk) model_step();

    // ---------------- monitor ----------------
    bit chk_on = 0;
    int n_hv, n_fall, n_miss, last_rt, low_len, last_low;
    logic prev_hitn = 1'b1;

    always @(negedge clk) if (chk_on) begin
        chk("lamp",         lamp,         m_lamp);
        chk("hit_n",        hit_n,        m_hitn);
        chk("hit_valid",    hit_valid,    m_hv);
        chk("miss",         miss,         m_miss);
        chk("reaction_ms",  reaction_ms,  m_rt);
        chk("sensor_clean", sensor_clean, m_clean);
        if (hit_valid === 1'b1) begin n_hv++; last_rt = int'(reaction_ms); end
        if (miss === 1'b1) n_miss++;
        if (prev_hitn === 1'b1 && hit_n === 1'b0) n_fall++;
        if (hit_n === 1'b0) low_len++;
        else if (prev_hitn === 1'b0) begin last_low = low_len; low_len = 0; end
        prev_hitn = hit_n;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        n_hv = 0; n_fall = 0; n_miss = 0; last_rt = -1; last_low = 0;
    endtask

    initial begin
        resetn = 1'b0; target_up = 1'b0; sensor_raw = 1'b0;
        clr(); low_len = 0;
        cyc(3);
        chk_on = 1;
        chk("reset_state", dut.state, IDLE);
        chk("reset_hit_n", hit_n, 1);
        resetn = 1'b1;
        cyc(2);

        // clean hit: sensor_clean rises 35 cycles after lamp lights
        clr();
        target_up = 1'b1;
        cyc(1);
        chk("s1_lamp_on", lamp, 1);
        cyc(29);
        sensor_raw = 1'b1;
        cyc(20);
        sensor_raw = 1'b0;
        cyc(10);
        target_up = 1'b0;
        cyc(10);
        chk("s1_hits", n_hv, 1);
        chk("s1_rt", last_rt, 3);
        chk("s1_low_len", last_low, PUL);
        chk("s1_falls", n_fall, 1);
        chk("s1_miss", n_miss, 0);

        // bounce rejection
        clr();
        target_up = 1'b1;
        cyc(5);
        for (int i = 0; i < 10; i++) begin
            sensor_raw = ~sensor_raw;
            cyc(2);
        end
        sensor_raw = 1'b1;
        cyc(15);
        sensor_raw = 1'b0;
        cyc(10);
        target_up = 1'b0;
        cyc(8);
        chk("s2_hits", n_hv, 1);
        chk("s2_falls", n_fall, 1);

        // miss
        clr();
        target_up = 1'b1;
        cyc(10);
        target_up = 1'b0;
        cyc(3);
        chk("s3_miss", n_miss, 1);
        chk("s3_lamp", lamp, 0);
        chk("s3_falls", n_fall, 0);

        // held-press arming
        clr();
        sensor_raw = 1'b1;
        cyc(10);
        target_up = 1'b1;
        cyc(20);
        chk("s3_held_nohit", n_hv, 0);
        sensor_raw = 1'b0;
        cyc(10);
        sensor_raw = 1'b1;
        cyc(10);
        chk("s3_repress_hit", n_hv, 1);
        sensor_raw = 1'b0;
        target_up = 1'b0;
        cyc(10);

        // saturation
        clr();
        target_up = 1'b1;
        cyc(200);
        sensor_raw = 1'b1;
        cyc(10);
        chk("s4_sat_rt", last_rt, RMAX);
        sensor_raw = 1'b0;
        target_up = 1'b0;
        cyc(10);

        // press and target_up fall on the same cycle
        clr();
        target_up = 1'b1;
        cyc(5);
        sensor_raw = 1'b1;
        for (int i = 0; i < 50 && !m_clean; i++) @(negedge clk);
        chk("s4_wait_clean", m_clean, 1);
        target_up = 1'b0;
        cyc(1);
        chk("s4_simul_hv", hit_valid, 1);
        chk("s4_simul_miss", miss, 0);
        cyc(1);
        sensor_raw = 1'b0;
        cyc(10);
        chk("s4_simul_nomiss", n_miss, 0);

        // only one hit per raise
        clr();
        target_up = 1'b1;
        cyc(3);
        sensor_raw = 1'b1;
        cyc(15);
        sensor_raw = 1'b0;
        cyc(10);
        sensor_raw = 1'b1;
        cyc(15);
        chk("s5_single_hit", n_hv, 1);
        sensor_raw = 1'b0;
        cyc(8);

        // reset during the hit pulse
        target_up = 1'b0;
        cyc(3);
        target_up = 1'b1;
        cyc(3);
        sensor_raw = 1'b1;
        for (int i = 0; i < 50 && m_hitn; i++) @(negedge clk);
        chk("s5_wait_pulse", hit_n, 0);
        resetn = 1'b0;
        cyc(1);
        chk("s5_rst_hit_n", hit_n, 1);
        chk("s5_rst_lamp", lamp, 0);
        chk("s5_rst_rt", reaction_ms, 0);
        chk("s5_rst_state", dut.state, IDLE);
        resetn = 1'b1;
        sensor_raw = 1'b0;
        target_up = 1'b0;
        cyc(10);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) sensor_raw = ~sensor_raw;
            if ($urandom_range(0, 39) == 0) target_up = ~target_up;
            resetn = ($urandom_range(0, 499) != 0);
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
